// File: rtl/addmax_seq_arb.sv
// Shared serial multi-operand add / abs-max reduction engine.
// An NREQ-way round-robin arbiter grants one requester per transaction.
module addmax_seq_arb #(
    parameter int N      = 23,
    parameter int NREQ   = 2,
    parameter int MAXOPS = 9,
    localparam int SW    = N + 4,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      in_valid,
    output logic [NREQ-1:0]      in_ready,
    input  logic [NREQ*N-1:0]    in_data,
    input  logic [NREQ-1:0]      in_last,
    input  logic [NREQ-1:0]      in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SW-1:0]        out_data,
    output logic [IDW-1:0]       out_id,
    output logic                 out_err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCUM  = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] RESULT = 2'd3;

    logic [1:0]     state;
    logic [IDW-1:0] g;
    logic [IDW-1:0] rr;
    logic [IDW-1:0] pick;
    logic           found;
    logic [SW-1:0]  acc;
    logic [3:0]     count;
    logic           err;
    logic           op;

    logic [N-1:0]   x;
    logic           sel_valid;
    logic           sel_last;
    logic           sel_op;
    logic           op_eff;
    logic           beat;
    logic [N:0]     xe;
    logic [N:0]     xabs;
    logic [SW-1:0]  abs_ext;
    logic [SW-1:0]  sext;
    logic [SW-1:0]  acc_next;

    // Round-robin pick: first valid requester at or after rr, wrapping.
    always_comb begin
        pick  = rr;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            int unsigned idx;
            idx = (32'(rr) + i) % 32'(NREQ);
            if (!found && in_valid[idx]) begin
                pick  = IDW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        x         = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_op    = 1'b0;
        in_ready  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (g == IDW'(i)) begin
                x         = in_data[i*N +: N];
                sel_valid = in_valid[i];
                sel_last  = in_last[i];
                sel_op    = in_op[i];
                if (state == ACCUM || state == DRAIN)
                    in_ready[i] = 1'b1;
            end
        end
    end

    assign out_valid = (state == RESULT);
    assign beat      = (state == ACCUM || state == DRAIN) && sel_valid;

    // |x| in N+1 bits so the most negative operand maps exactly.
    always_comb begin
        op_eff   = (count == 4'd0) ? sel_op : op;
        xe       = {x[N-1], x};
        xabs     = x[N-1] ? (~xe + 1'b1) : xe;
        abs_ext  = SW'(xabs);
        sext     = SW'(signed'(x));
        acc_next = op_eff ? ((acc > abs_ext) ? acc : abs_ext) : (acc + sext);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            g        <= '0;
            rr       <= '0;
            acc      <= '0;
            count    <= '0;
            err      <= 1'b0;
            op       <= 1'b0;
            out_data <= '0;
            out_id   <= '0;
            out_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|in_valid) begin
                        g     <= pick;
                        acc   <= '0;
                        count <= '0;
                        err   <= 1'b0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc   <= acc_next;
                        count <= count + 4'd1;
                        if (count == 4'd0)
                            op <= sel_op;
                        if (sel_last) begin
                            state    <= RESULT;
                            out_data <= acc_next;
                            out_id   <= g;
                            out_err  <= 1'b0;
                        end else if (count + 4'd1 == 4'(MAXOPS)) begin
                            err   <= 1'b1;
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (beat && sel_last) begin
                        state    <= RESULT;
                        out_data <= acc;
                        out_id   <= g;
                        out_err  <= err;
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        rr    <= (g == IDW'(NREQ - 1)) ? '0 : g + 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
